ps2_receiver: RTL

Synthesizable PS/2 device-to-host receiver that consumes the `ps2_clk`/`ps2_data` line pair produced by a PS/2 keyboard, or by the bench keyboard model in simulation. It synchronises both lines into the system clock domain and deserialises 11-bit frames (start, 8 data bits LSB-first, odd parity, stop). Valid scan-code bytes are pushed into a small first-word-fall-through FIFO, which the downstream scan-code decoder pops.

---
 rtl/ps2_receiver.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_receiver.sv
// rtl/ps2_receiver.sv - PS/2 device-to-host frame receiver with FWFT scan-code FIFO (optional parity check: PS2_RX_PARITY_EN)
module ps2_receiver #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // synchroniser stages; the clock line gets one extra stage so edges can be detected
  logic [2:0] clk_sync;
  logic [1:0] data_sync;
  logic       fall;
  logic       sample;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic [TW-1:0] tmo_cnt;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic parity_ok;
  logic frame_good;
  logic do_pop;
  logic do_push;

  // bring both raw lines into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign fall   = clk_sync[2] & ~clk_sync[1];
  assign sample = data_sync[1];

`ifdef PS2_RX_PARITY_EN
  logic parity_bit;
  logic parity_err_q;
  // odd parity over the eight data bits plus the parity bit
  assign parity_ok  = ^{shift_reg, parity_bit};
  assign parity_err = parity_err_q;
`else
  assign parity_ok  = 1'b1;
  assign parity_err = 1'b0;
`endif

  // a complete, well-formed frame is on its stop bit this cycle
  assign frame_good = (state == STOP) && fall && sample && parity_ok;

  // a pop on an empty FIFO is ignored; a pop frees room for a same-cycle push
  assign do_pop  = rd_en && !empty;
  assign do_push = frame_good && (!full || do_pop);

  // frame deserialiser, mid-frame timeout and registered error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      shift_reg    <= 8'd0;
      tmo_cnt      <= '0;
      frame_err    <= 1'b0;
      overflow     <= 1'b0;
`ifdef PS2_RX_PARITY_EN
      parity_bit   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
`ifdef PS2_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (state == IDLE || fall) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      if (state != IDLE && !fall && tmo_cnt == TMO_LAST) begin
        // keyboard stopped clocking mid-frame: abandon it
        state     <= IDLE;
        tmo_cnt   <= '0;
        frame_err <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (fall && !sample) begin
              state     <= DATA;
              bit_cnt   <= 3'd0;
              shift_reg <= 8'd0;
            end
          end
          DATA: begin
            if (fall) begin
              shift_reg[bit_cnt] <= sample;
              if (bit_cnt == 3'd7) begin
                state <= PARITY;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          PARITY: begin
            if (fall) begin
`ifdef PS2_RX_PARITY_EN
              parity_bit <= sample;
`endif
              state <= STOP;
            end
          end
          STOP: begin
            if (fall) begin
              state <= IDLE;
              if (!sample) begin
                frame_err <= 1'b1;
              end else if (!parity_ok) begin
`ifdef PS2_RX_PARITY_EN
                parity_err_q <= 1'b1;
`endif
              end else if (!do_push) begin
                overflow <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // FIFO pointers; the extra MSB distinguishes full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW + 1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW + 1)'(1);
      end
    end
  end

  // FIFO storage needs no reset; contents are only visible behind the pointers
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= shift_reg;
    end
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule
